// File: rtl/lsu_unit_pkg.sv
// rtl/lsu_unit_pkg.sv - shared funct3 codes, fault codes, state encoding and helpers for the LSU
package lsu_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT_R = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } lsu_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - access legality check, store lane generation and load extract/extend
module lsu_align
    import lsu_unit_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        illegal = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Loads always fetch the whole word; the extract picks the lane afterwards.
    always_comb begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                if (we) be = 4'b0001 << addr[1:0];
                wdata_lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                if (we) be = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_offset, 3'b000};
        ld_data = shifted;
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'h000000, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'h0000, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - load/store unit: request FSM, bus timeout and write-back/fault generation
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_addr_i,
    output logic        req_ready_o,
    output logic        hold_o,
    output logic        reg_wr_en_o,
    output logic [4:0]  reg_wr_addr_o,
    output logic [31:0] reg_wr_data_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic [31:0] fault_addr_o,
    output logic        rib_req_o,
    output logic        rib_we_o,
    output logic [31:0] rib_addr_o,
    output logic [3:0]  rib_be_o,
    output logic [31:0] rib_wdata_o,
    input  logic        rib_gnt_i,
    input  logic        rib_rvalid_i,
    input  logic [31:0] rib_rdata_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [4:0]  rd_q;
    logic [31:0] rib_addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] ld_q;
    logic [1:0]  fault_code_q;
    logic [CW-1:0] cnt_q;

    logic        illegal, misaligned, timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata_lanes, ld_data;

    lsu_align u_align (
        .we          (req_we_i),
        .funct3      (req_funct3_i),
        .addr        (req_addr_i),
        .wdata       (req_wdata_i),
        .ld_funct3   (funct3_q),
        .ld_offset   (addr_q[1:0]),
        .rdata       (rib_rdata_i),
        .illegal     (illegal),
        .misaligned  (misaligned),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .ld_data     (ld_data)
    );

    // The counter spans REQ and WAIT_R, so a late grant can leave WAIT_R already expired.
    assign timeout_hit = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) state_d = (illegal || misaligned) ? ST_FAULT : ST_REQ;
            end
            ST_REQ: begin
                if (rib_gnt_i)        state_d = we_q ? ST_DONE : ST_WAIT_R;
                else if (timeout_hit) state_d = ST_FAULT;
            end
            ST_WAIT_R: begin
                if (rib_rvalid_i)     state_d = ST_DONE;
                else if (timeout_hit) state_d = ST_FAULT;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= ZERO_WORD;
            rd_q         <= 5'd0;
            rib_addr_q   <= ZERO_WORD;
            be_q         <= 4'b0000;
            wdata_q      <= ZERO_WORD;
            ld_q         <= ZERO_WORD;
            fault_code_q <= FAULT_NONE;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid_i) begin
                we_q         <= req_we_i;
                funct3_q     <= req_funct3_i;
                addr_q       <= req_addr_i;
                rd_q         <= req_rd_addr_i;
                cnt_q        <= '0;
                fault_code_q <= illegal ? FAULT_ILLEGAL :
                                misaligned ? FAULT_MISALIGN : FAULT_NONE;
                if (!(illegal || misaligned)) begin
                    rib_addr_q <= word_align(req_addr_i);
                    be_q       <= be;
                    wdata_q    <= wdata_lanes;
                end
            end
            if (state_q == ST_REQ || state_q == ST_WAIT_R) begin
                cnt_q <= cnt_q + CW'(1);
                if (state_d == ST_FAULT) fault_code_q <= FAULT_TIMEOUT;
            end
            if (state_q == ST_WAIT_R && rib_rvalid_i) ld_q <= ld_data;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign hold_o        = (state_q != ST_IDLE) || req_valid_i;
    assign rib_req_o     = (state_q == ST_REQ);
    assign rib_we_o      = we_q;
    assign rib_addr_o    = rib_addr_q;
    assign rib_be_o      = be_q;
    assign rib_wdata_o   = wdata_q;
    assign reg_wr_en_o   = (state_q == ST_DONE) && !we_q && (rd_q != 5'd0);
    assign reg_wr_addr_o = rd_q;
    assign reg_wr_data_o = ld_q;
    assign fault_o       = (state_q == ST_FAULT);
    assign fault_code_o  = fault_code_q;
    assign fault_addr_o  = addr_q;

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - scoreboard bench for lsu_unit
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        req_ready, hold;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_addr;
    logic        rib_req, rib_we;
    logic [31:0] rib_addr, rib_wdata;
    logic [3:0]  rib_be;
    logic        rib_gnt, rib_rvalid;
    logic [31:0] rib_rdata;

    always #5 clk = ~clk;

    lsu_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_we_i      (req_we),
        .req_funct3_i  (req_funct3),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_rd_addr_i (req_rd),
        .req_ready_o   (req_ready),
        .hold_o        (hold),
        .reg_wr_en_o   (reg_wr_en),
        .reg_wr_addr_o (reg_wr_addr),
        .reg_wr_data_o (reg_wr_data),
        .fault_o       (fault),
        .fault_code_o  (fault_code),
        .fault_addr_o  (fault_addr),
        .rib_req_o     (rib_req),
        .rib_we_o      (rib_we),
        .rib_addr_o    (rib_addr),
        .rib_be_o      (rib_be),
        .rib_wdata_o   (rib_wdata),
        .rib_gnt_i     (rib_gnt),
        .rib_rvalid_i  (rib_rvalid),
        .rib_rdata_i   (rib_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] addr;
    } flt_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    flt_t flt_q[$];

    int total = 0;
    int bad   = 0;
    int hold_cnt = 0;
    int req_cnt  = 0;
    int wb_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hold)    hold_cnt <= hold_cnt + 1;
        if (rib_req) req_cnt  <= req_cnt + 1;
        if (reg_wr_en) wb_cnt <= wb_cnt + 1;
        if (rib_req && rib_gnt) begin
            if (bus_q.size() == 0) check_eq("bus_unexp_qsize", bus_q.size(), 1);
            else begin
                check_eq("bus_addr", rib_addr, bus_q[0].addr);
                check_eq("bus_we", {31'b0, rib_we}, {31'b0, bus_q[0].we});
                check_eq("bus_be", {28'b0, rib_be}, {28'b0, bus_q[0].be});
                if (bus_q[0].we) check_eq("bus_wdata", rib_wdata, bus_q[0].wdata);
                void'(bus_q.pop_front());
            end
        end
        if (reg_wr_en) begin
            if (wb_q.size() == 0) check_eq("wb_unexp_qsize", wb_q.size(), 1);
            else begin
                check_eq("wb_rd", {27'b0, reg_wr_addr}, {27'b0, wb_q[0].rd});
                check_eq("wb_data", reg_wr_data, wb_q[0].data);
                void'(wb_q.pop_front());
            end
        end
        if (fault) begin
            if (flt_q.size() == 0) check_eq("flt_unexp_qsize", flt_q.size(), 1);
            else begin
                check_eq("flt_code", {30'b0, fault_code}, {30'b0, flt_q[0].code});
                check_eq("flt_addr", fault_addr, flt_q[0].addr);
                void'(flt_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic respond(input logic we, input int gnt_wait, input logic [31:0] rd_data,
                           input int rv_wait);
        repeat (gnt_wait) tick();
        rib_gnt = 1'b1;
        tick();
        rib_gnt = 1'b0;
        if (!we) begin
            repeat (rv_wait) tick();
            rib_rvalid = 1'b1;
            rib_rdata  = rd_data;
            tick();
            rib_rvalid = 1'b0;
            rib_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 60) begin
            tick();
            n++;
        end
        check_eq("idle_reached", {31'b0, req_ready}, 32'd1);
    endtask

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (!we) return 4'b1111;
        case (f3)
            3'b000:  return (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                            (off == 2'd2) ? 4'b0100 : 4'b1000;
            3'b001:  return (off == 2'd0) ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            3'b001:  return {wd[15:0], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = (off == 2'd0) ? d[7:0] : (off == 2'd1) ? d[15:8] : (off == 2'd2) ? d[23:16] : d[31:24];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int h0, r0, w0;
        logic [2:0]  ld_tab [5];
        logic [2:0]  f3;
        logic [31:0] a, wd, rdd;
        logic        we;
        logic [4:0]  rd;

        ld_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        rib_gnt = 1'b0; rib_rvalid = 1'b0; rib_rdata = 32'h0;
        repeat (3) tick();
        check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst_hold", {31'b0, hold}, 32'd0);
        check_eq("rst_rib_req", {31'b0, rib_req}, 32'd0);
        check_eq("rst_rib_addr", rib_addr, 32'h0);
        check_eq("rst_rib_be", {28'b0, rib_be}, 32'd0);
        check_eq("rst_wb_fault", {30'b0, reg_wr_en, fault}, 32'd0);
        rst_n = 1'b1;
        tick();

        // SB at offset 3, grant after two wait cycles
        bus_q.push_back('{addr: 32'h0000_1000, we: 1'b1, be: 4'b1000, wdata: 32'hA5A5_A5A5});
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd9);
        h0 = hold_cnt;
        respond(1'b1, 2, 32'h0, 0);
        wait_idle();
        check_eq("sb_hold_cycles", hold_cnt - h0, 32'd4);

        // LB and LBU at offset 2
        bus_q.push_back('{addr: 32'h0000_2000, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        wb_q.push_back('{rd: 5'd5, data: 32'hFFFF_FF80});
        issue(1'b0, 3'b000, 32'h0000_2002, 32'h0, 5'd5);
        respond(1'b0, 0, 32'h1280_3456, 0);
        wait_idle();
        bus_q.push_back('{addr: 32'h0000_2000, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        wb_q.push_back('{rd: 5'd5, data: 32'h0000_0080});
        issue(1'b0, 3'b100, 32'h0000_2002, 32'h0, 5'd5);
        respond(1'b0, 1, 32'h1280_3456, 2);
        wait_idle();

        // misaligned LH: fault visible in the first cycle, no bus request
        flt_q.push_back('{code: 2'b01, addr: 32'h0000_2001});
        r0 = req_cnt;
        issue(1'b0, 3'b001, 32'h0000_2001, 32'h0, 5'd3);
        check_eq("mis_fault_cycle1", {31'b0, fault}, 32'd1);
        wait_idle();
        check_eq("mis_no_bus", req_cnt - r0, 32'd0);

        flt_q.push_back('{code: 2'b10, addr: 32'h0000_2400});
        r0 = req_cnt;
        issue(1'b0, 3'b011, 32'h0000_2400, 32'h0, 5'd3);
        wait_idle();
        check_eq("ill_no_bus", req_cnt - r0, 32'd0);

        // timeout with grant held low
        flt_q.push_back('{code: 2'b11, addr: 32'h0000_3004});
        r0 = req_cnt;
        issue(1'b0, 3'b010, 32'h0000_3004, 32'h0, 5'd4);
        wait_idle();
        check_eq("to_req_cycles", req_cnt - r0, 32'd16);
        check_eq("to_req_low", {31'b0, rib_req}, 32'd0);

        // grant in the last allowed REQ cycle wins over expiry
        bus_q.push_back('{addr: 32'h0000_5000, we: 1'b1, be: 4'b1111, wdata: 32'hCAFE_BABE});
        issue(1'b1, 3'b010, 32'h0000_5000, 32'hCAFE_BABE, 5'd0);
        respond(1'b1, 15, 32'h0, 0);
        wait_idle();

        // reset while waiting for read data
        bus_q.push_back('{addr: 32'h0000_3000, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd7);
        rib_gnt = 1'b1;
        tick();
        rib_gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        check_eq("rstw_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rstw_rib_req", {31'b0, rib_req}, 32'd0);
        check_eq("rstw_rib_addr", rib_addr, 32'h0);
        rst_n = 1'b1;
        w0 = wb_cnt;
        rib_rvalid = 1'b1;
        rib_rdata  = 32'h7777_7777;
        tick();
        rib_rvalid = 1'b0;
        repeat (3) tick();
        check_eq("rstw_no_wb", wb_cnt - w0, 32'd0);

        // back-to-back SW then LW to x0
        bus_q.push_back('{addr: 32'h0000_4008, we: 1'b1, be: 4'b1111, wdata: 32'h1122_3344});
        bus_q.push_back('{addr: 32'h0000_400C, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        w0 = wb_cnt;
        issue(1'b1, 3'b010, 32'h0000_4008, 32'h1122_3344, 5'd0);
        respond(1'b1, 0, 32'h0, 0);
        wait_idle();
        check_eq("b2b_hold_low", {31'b0, hold}, 32'd0);
        issue(1'b0, 3'b010, 32'h0000_400C, 32'h0, 5'd0);
        respond(1'b0, 0, 32'h5555_AAAA, 0);
        wait_idle();
        check_eq("b2b_no_wb", wb_cnt - w0, 32'd0);

        // random legal accesses
        for (int i = 0; i < 16; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)];
            a  = $urandom;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            wd  = $urandom;
            rdd = $urandom;
            rd  = 5'($urandom_range(0, 31));
            bus_q.push_back('{addr: {a[31:2], 2'b00}, we: we, be: model_be(we, f3, a[1:0]),
                              wdata: model_wdata(f3, wd)});
            if (!we && rd != 5'd0) wb_q.push_back('{rd: rd, data: model_load(f3, a[1:0], rdd)});
            issue(we, f3, a, wd, rd);
            respond(we, $urandom_range(0, 3), rdd, $urandom_range(0, 3));
            wait_idle();
        end

        tick();
        check_eq("bus_q_left", bus_q.size(), 32'd0);
        check_eq("wb_q_left", wb_q.size(), 32'd0);
        check_eq("flt_q_left", flt_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
